// File: rtl/orion_soc_types.sv
// SoC-level constants: UART address map, STATUS bit layout and TX FSM states.
package orion_soc_types;

  import orion_types::*;

  // Base address the SoC decoder uses to select the UART
  localparam logic [ADDRW-1:0] UART_BASE_ADDR = 32'h1000_0000;

  // Register byte offsets inside the UART window
  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;
  localparam logic [3:0] UART_IRQEN   = 4'hC;

  // STATUS register bit positions
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_MSB = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/orion_types.sv
// Core-wide bus widths shared by every data-memory responder in orion_soc.
package orion_types;

  localparam int ADDRW = 32;
  localparam int DATAW = 32;
  localparam int MASKW = DATAW / 8;

endpackage

// File: rtl/orion_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and pop
// when empty, so callers may drive the strobes unconditionally.
module orion_sync_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATAW-1:0]         wr_data,
  output logic [DATAW-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; level tracks simultaneous push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/orion_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory valid/resp bus.
// Optional interrupt (IRQEN register and irq_o port) is built only when the
// macro ORION_UART_IRQ_EN is defined.
module orion_uart_tx
  import orion_types::*;
  import orion_soc_types::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic [DATAW-1:0] wdata_i,
  input  logic [MASKW-1:0] mask_i,
  input  logic             we_i,
  input  logic             valid_i,
  output logic [DATAW-1:0] rdata_o,
  output logic             resp_o,
  output logic             tx_o
`ifdef ORION_UART_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e state;
  uart_tx_state_e state_d;
  logic [15:0]    bit_cnt;
  logic [15:0]    bit_cnt_d;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_idx_d;
  logic [7:0]     shift;
  logic [7:0]     shift_d;
  logic           tx_q;
  logic           tx_d;
  logic           busy;

  logic             resp_q;
  logic [DATAW-1:0] rdata_q;
  logic [DATAW-1:0] rd_mux;
  logic [15:0]      baud_div;
  logic             ovf;

  logic       accept;
  logic       wr_en;
  logic [3:0] reg_off;
  logic       push_req;
  logic       fifo_push;
  logic       fifo_pop;
  logic       ovf_set;
  logic       ovf_clr;
  logic       fifo_full;
  logic       fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_rd_data;

`ifdef ORION_UART_IRQ_EN
  logic irq_en;
  logic irq_q;
`endif

  // Only address bits [3:2] and the low data/mask lanes carry meaning here
  logic unused_bits;
  assign unused_bits = ^{addr_i[ADDRW-1:4], addr_i[1:0],
                         wdata_i[DATAW-1:16], mask_i[MASKW-1:2]};

  // A request is taken only when no response is outstanding
  assign accept  = valid_i & ~resp_q;
  assign wr_en   = accept & we_i;
  assign reg_off = {addr_i[3:2], 2'b00};

  // Full is judged before any same-cycle pop, so a full FIFO always drops
  assign push_req  = wr_en & (reg_off == UART_TXDATA) & mask_i[0];
  assign fifo_push = push_req & ~fifo_full;
  assign ovf_set   = push_req & fifo_full;
  assign ovf_clr   = wr_en & (reg_off == UART_STATUS) & mask_i[0] & wdata_i[STAT_OVF];

  orion_sync_fifo #(
    .DATAW (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wdata_i[7:0]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Register read mux; reads never change state
  always_comb begin
    rd_mux = '0;
    case (reg_off)
      UART_STATUS: begin
        rd_mux[STAT_FULL]  = fifo_full;
        rd_mux[STAT_EMPTY] = fifo_empty;
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_OVF]   = ovf;
        rd_mux[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = 8'(fifo_level);
      end
      UART_BAUDDIV: rd_mux[15:0] = baud_div;
`ifdef ORION_UART_IRQ_EN
      UART_IRQEN:   rd_mux[0] = irq_en;
`else
      UART_IRQEN:   rd_mux = '0;
`endif
      default:      rd_mux = '0;
    endcase
  end

  // One-cycle response strobe; read data is held at zero outside it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= accept;
      rdata_q <= (accept & ~we_i) ? rd_mux : '0;
    end
  end

  // Overflow flag (a same-cycle set beats the clear) and byte-masked divisor
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf      <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (wr_en && reg_off == UART_BAUDDIV) begin
        if (mask_i[0]) baud_div[7:0]  <= wdata_i[7:0];
        if (mask_i[1]) baud_div[15:8] <= wdata_i[15:8];
      end
    end
  end

`ifdef ORION_UART_IRQ_EN
  // Interrupt enable and level interrupt; a push this cycle drops it next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && reg_off == UART_IRQEN && mask_i[0]) begin
        irq_en <= wdata_i[0];
      end
      irq_q <= irq_en & fifo_empty & ~busy & ~fifo_push;
    end
  end

  assign irq_o = irq_q;
`endif

  // TX state register, bit timing counters, shift register and registered line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; the divisor is sampled only at each counter reload
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rd_data;
          bit_cnt_d = baud_div;
          state_d   = START;
        end
      end
      START: begin
        if (bit_cnt == '0) begin
          bit_cnt_d = baud_div;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          bit_cnt_d = baud_div;
          shift_d   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt == '0) begin
          state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming state, so tx_o is a clean flop output
  always_comb begin
    busy = (state != IDLE);
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o    = tx_q;
  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_orion_uart_tx.sv
// Directed bench for orion_uart_tx: reset, single frame, back-to-back frames,
// bus handshake, FIFO overflow, asynchronous reset and (with ORION_UART_IRQ_EN)
// the interrupt.
module tb_orion_uart_tx;

  import orion_types::*;
  import orion_soc_types::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [ADDRW-1:0] addr_i;
  logic [DATAW-1:0] wdata_i;
  logic [MASKW-1:0] mask_i;
  logic             we_i;
  logic             valid_i;
  logic [DATAW-1:0] rdata_o;
  logic             resp_o;
  logic             tx_o;
`ifdef ORION_UART_IRQ_EN
  logic             irq_o;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_accept = 0;
  logic tx_hist [0:8191];

  logic [31:0] rd;
  logic        rs;
  logic [9:0]  exp_frame;
  logic [9:0]  got_frame;
  logic [3:0]  samples;
  logic [6:0]  resp_seq;
  int          rd_good;
  int          rd_zero_bad;
  int          a;
  int          f;
  logic        tail_ok;

  orion_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd867)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .mask_i  (mask_i),
    .we_i    (we_i),
    .valid_i (valid_i),
    .rdata_o (rdata_o),
    .resp_o  (resp_o),
    .tx_o    (tx_o)
`ifdef ORION_UART_IRQ_EN
    ,
    .irq_o   (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (cyc < 8192) tx_hist[cyc] = tx_o;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [3:0] off,
                               input logic [31:0] data, input logic [3:0] mask,
                               output logic [31:0] rdata, output logic resp);
    @(negedge clk_i);
    addr_i      = UART_BASE_ADDR | ADDRW'(off);
    wdata_i     = data;
    mask_i      = mask;
    we_i        = write;
    valid_i     = 1'b1;
    last_accept = cyc;
    @(negedge clk_i);
    rdata   = rdata_o;
    resp    = resp_o;
    valid_i = 1'b0;
    we_i    = 1'b0;
  endtask

  task automatic writeReg(input logic [3:0] off, input logic [31:0] data,
                          input logic [3:0] mask);
    logic [31:0] d;
    logic        r;
    applyStimulus(1'b1, off, data, mask, d, r);
  endtask

  task automatic readReg(input logic [3:0] off, output logic [31:0] data);
    logic r;
    applyStimulus(1'b0, off, 32'h0, 4'h0, data, r);
  endtask

  function automatic logic [9:0] frameOf(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [9:0] frameAt(input int s, input int p);
    logic [9:0] fr;
    for (int j = 0; j < 10; j++) fr[j] = tx_hist[s + j * p];
    return fr;
  endfunction

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    mask_i  = '0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_i);
    checkOutput("rst_tx", 32'(tx_o), 32'h1);
    checkOutput("rst_resp", 32'(resp_o), 32'h0);
    checkOutput("rst_rdata", rdata_o, 32'h0);
    rst_i = 1'b0;
    readReg(UART_STATUS, rd);
    checkOutput("rst_status", rd, 32'h0000_0002);
    readReg(UART_BAUDDIV, rd);
    checkOutput("rst_bauddiv", rd, 32'd867);
    readReg(UART_IRQEN, rd);
    checkOutput("rst_irqen", rd, 32'h0);

    // ---------------- single byte, BAUDDIV=3 ----------------
    writeReg(UART_BAUDDIV, 32'd3, 4'h3);
    applyStimulus(1'b1, UART_TXDATA, 32'h0000_00A5, 4'h1, rd, rs);
    checkOutput("single_resp", 32'(rs), 32'h1);
    checkOutput("single_tx_idle_n1", 32'(tx_o), 32'h1);
    exp_frame = frameOf(8'hA5);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_i);
        samples[k] = tx_o;
      end
      checkOutput($sformatf("single_bit%0d", b), 32'(samples), 32'({4{exp_frame[b]}}));
    end
    readReg(UART_STATUS, rd);
    checkOutput("single_done_status", rd, 32'h0000_0002);

    // ---------------- back-to-back frames, BAUDDIV=0 ----------------
    writeReg(UART_BAUDDIV, 32'd0, 4'h3);
    writeReg(UART_TXDATA, 32'h00, 4'h1);
    a = last_accept;
    writeReg(UART_TXDATA, 32'hFF, 4'h1);
    repeat (30) @(negedge clk_i);
    checkOutput("b2b_pre_idle", 32'(tx_hist[a + 1]), 32'h1);
    checkOutput("b2b_frame0", 32'(frameAt(a + 2, 1)), 32'(frameOf(8'h00)));
    checkOutput("b2b_gap", 32'(tx_hist[a + 12]), 32'h1);
    checkOutput("b2b_frame1", 32'(frameAt(a + 13, 1)), 32'(frameOf(8'hFF)));
    checkOutput("b2b_post_idle", 32'(tx_hist[a + 23]), 32'h1);

    // ---------------- bus protocol: valid held 6 cycles ----------------
    @(negedge clk_i);
    addr_i      = UART_BASE_ADDR | ADDRW'(UART_STATUS);
    we_i        = 1'b0;
    mask_i      = 4'h0;
    valid_i     = 1'b1;
    resp_seq    = '0;
    rd_good     = 0;
    rd_zero_bad = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      resp_seq[k] = resp_o;
      if (resp_o && rdata_o == 32'h0000_0002) rd_good++;
      if (!resp_o && rdata_o != 32'h0) rd_zero_bad++;
      if (k == 5) valid_i = 1'b0;
    end
    checkOutput("bus_resp_pattern", 32'(resp_seq), 32'h0000_0015);
    checkOutput("bus_resp_count", 32'($countones(resp_seq)), 32'd3);
    checkOutput("bus_rdata_valid", 32'(rd_good), 32'd3);
    checkOutput("bus_rdata_zero", 32'(rd_zero_bad), 32'd0);
    readReg(UART_TXDATA, rd);
    checkOutput("txdata_reads_zero", rd, 32'h0);
    writeReg(UART_IRQEN, 32'hFFFF_FFFF, 4'hF);
    readReg(UART_IRQEN, rd);
`ifdef ORION_UART_IRQ_EN
    checkOutput("irqen_rw", rd, 32'h1);
`else
    checkOutput("off_c_ignored", rd, 32'h0);
`endif
    readReg(UART_BAUDDIV, rd);
    checkOutput("bauddiv_undisturbed", rd, 32'h0);

    // ---------------- FIFO fill and overflow, BAUDDIV=1000 ----------------
    writeReg(UART_BAUDDIV, 32'd1000, 4'h3);
    f = 0;
    for (int i = 0; i < 9; i++) begin
      writeReg(UART_TXDATA, 32'(8'h10 + 8'(i)), 4'h1);
      if (i == 0) f = last_accept;
    end
    readReg(UART_STATUS, rd);
    checkOutput("fifo_full_status", rd, 32'h0000_0805);
    writeReg(UART_TXDATA, 32'h99, 4'h1);
    readReg(UART_STATUS, rd);
    checkOutput("ovf_set_status", rd, 32'h0000_080D);
    writeReg(UART_STATUS, 32'h8, 4'h1);
    readReg(UART_STATUS, rd);
    checkOutput("ovf_clear_status", rd, 32'h0000_0805);
    writeReg(UART_BAUDDIV, 32'd0, 4'h3);
    while (cyc < f + 1130) @(negedge clk_i);
    got_frame[0] = tx_hist[f + 2] | tx_hist[f + 1002];
    for (int i = 0; i < 8; i++) got_frame[1 + i] = tx_hist[f + 1003 + i];
    got_frame[9] = tx_hist[f + 1011];
    checkOutput("ovf_frame0_slow_start", 32'(got_frame), 32'(frameOf(8'h10)));
    for (int k = 1; k < 9; k++) begin
      checkOutput($sformatf("ovf_frame%0d", k),
                  32'(frameAt(f + 1013 + 11 * (k - 1), 1)),
                  32'(frameOf(8'h10 + 8'(k))));
    end
    tail_ok = 1'b1;
    for (int c = f + 1100; c < f + 1130; c++) tail_ok = tail_ok & tx_hist[c];
    checkOutput("ovf_byte_dropped", 32'(tail_ok), 32'h1);

    // ---------------- asynchronous reset mid-frame ----------------
    writeReg(UART_BAUDDIV, 32'd3, 4'h3);
    writeReg(UART_TXDATA, 32'h00, 4'h1);
    writeReg(UART_TXDATA, 32'h55, 4'h1);
    repeat (5) @(negedge clk_i);
    checkOutput("midframe_tx_low", 32'(tx_o), 32'h0);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("async_rst_tx", 32'(tx_o), 32'h1);
    checkOutput("async_rst_resp", 32'(resp_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    readReg(UART_STATUS, rd);
    checkOutput("post_rst_status", rd, 32'h0000_0002);
    readReg(UART_BAUDDIV, rd);
    checkOutput("post_rst_bauddiv", rd, 32'd867);

`ifdef ORION_UART_IRQ_EN
    // ---------------- interrupt ----------------
    checkOutput("irq_reset", 32'(irq_o), 32'h0);
    writeReg(UART_BAUDDIV, 32'd3, 4'h3);
    writeReg(UART_IRQEN, 32'h1, 4'h1);
    @(negedge clk_i);
    checkOutput("irq_set", 32'(irq_o), 32'h1);
    writeReg(UART_TXDATA, 32'h3C, 4'h1);
    checkOutput("irq_drop_after_push", 32'(irq_o), 32'h0);
    repeat (41) @(negedge clk_i);
    checkOutput("irq_low_before_idle", 32'(irq_o), 32'h0);
    @(negedge clk_i);
    checkOutput("irq_back_after_stop", 32'(irq_o), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/orion_uart_tx.md
Name: orion_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the core's data-memory valid/resp bus.
- Sits in orion_soc beside dmem, selected by the SoC address decode.
- Buffers bytes written by the core in a small FIFO and serialises them 8N1, LSB first, on tx_o.
- Exposes status and baud-divisor registers for software polling.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, >=2.
- DEFAULT_DIV, 16'd867, reset value of BAUDDIV; bit period = BAUDDIV+1 clk cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- addr_i  in  ADDRW  byte address; only [3:2] decoded
- wdata_i  in  DATAW  write data
- mask_i  in  MASKW  byte-enable mask
- we_i  in  1  1=write, 0=read
- valid_i  in  1  request valid
- rdata_o  out  DATAW  read data, valid while resp_o=1
- resp_o  out  1  response strobe
- tx_o  out  1  serial output, idle high
- irq_o  out  1  interrupt; present only with ORION_UART_IRQ_EN

Behaviour:
- Reset: resp_o=0, rdata_o=0, tx_o=1, FIFO empty, FSM=IDLE, BAUDDIV=DEFAULT_DIV, OVF=0. Reset is asynchronous and active-high, so tx_o returns high immediately, even mid-frame, and all queued bytes are lost.
- Handshake:
  - A request is accepted in cycle N when valid_i=1 and resp_o=0.
  - resp_o=1 for exactly one cycle, N+1, with rdata_o valid in that cycle; rdata_o=0 whenever resp_o=0.
  - A valid_i held high during the resp cycle is not accepted, so the maximum rate is one request per 2 cycles.
  - Writes take effect at the end of cycle N.
- Register map (word offsets):
  - 0x0 TXDATA: W pushes wdata_i[7:0] if mask_i[0]. If the FIFO is full, the byte is dropped and OVF is set. Full is evaluated before any same-cycle pop. R returns 0.
  - 0x4 STATUS:
    - R fields: [0] full, [1] empty, [2] busy (FSM != IDLE), [3] OVF, [15:8] FIFO level (0..FIFO_DEPTH), all other bits 0.
    - W: wdata_i[3]=1 with mask_i[0] clears OVF. A same-cycle overflow set wins over the clear.
  - 0x8 BAUDDIV: RW [15:0], byte-masked by mask_i[1:0]; upper bits read 0. A new value takes effect at the next bit-counter reload; the current bit completes at the old rate.
  - 0xC: IRQEN with the macro; otherwise reads 0 and writes are ignored.
  - Reads have no side effects.
- TX FSM (states IDLE, START, DATA, STOP):
  - IDLE: if FIFO non-empty, pop into the shift register, load bit counter=BAUDDIV, go to START.
  - START: tx_o=0 for BAUDDIV+1 cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] per bit period, shift right; after bit index 7, go to STOP.
  - STOP: tx_o=1 for one bit period, then go to IDLE. The next pop happens in that IDLE cycle, so there is one idle cycle between frames.
- tx_o is registered.
- Latency: TXDATA write accepted in cycle N with the FSM idle and the FIFO empty → pop in N+1 → start bit begins in N+2. Frame length is 10*(BAUDDIV+1) cycles.
- BAUDDIV=0: one cycle per bit; legal.
- FIFO pointers wrap modulo FIFO_DEPTH. The level counter is $clog2(FIFO_DEPTH)+1 bits wide.
- Push into a non-empty FIFO and a pop in the same cycle: both occur and the level is unchanged.

Optional Feature:
- Macro: ORION_UART_IRQ_EN.
- With the macro:
  - Offset 0xC becomes IRQEN (bit0 RW, reset 0).
  - irq_o = registered (IRQEN & empty & ~busy), level-sensitive.
  - irq_o deasserts the cycle after the next TXDATA push.
- Without the macro: the irq_o port and IRQEN register are absent, and 0xC reads 0.

Decomposition:
- Shared package orion_soc_types holds:
  - register offsets UART_TXDATA/UART_STATUS/UART_BAUDDIV/UART_IRQEN;
  - STATUS bit-position constants;
  - enum uart_tx_state_e {IDLE, START, DATA, STOP};
  - the UART base address constant for the SoC decoder.
- ADDRW, DATAW and MASKW come from orion_types.
- One sub-module, orion_sync_fifo (params DATAW, DEPTH; push/pop/full/empty/level), which is reusable for a future RX path.

Test Plan:
- Reset mid-frame: assert rst_i during DATA → tx_o=1 in the same cycle (async). After release: STATUS reads 0x0000_0002, BAUDDIV reads 867.
- Single byte: BAUDDIV=3, write 0xA5 to TXDATA at cycle N → resp_o at N+1, tx_o low at N+2 for 4 cycles. Data bits then read 1,0,1,0,0,1,0,1 at 4 cycles each, followed by a 4-cycle stop; busy=0 40 cycles after the start bit.
- FIFO fill/overflow with FIFO_DEPTH=8: write 9 bytes while BAUDDIV=1000 (the first pops, so 8 remain queued) → STATUS level=8, full=1. A 10th write sets OVF=1 and that byte is never transmitted. Writing STATUS with 0x8 clears OVF.
- Back-to-back frames: queue 0x00,0xFF with BAUDDIV=0 → two 10-cycle frames separated by exactly one idle-high cycle; a monitor decodes both bytes.
- Bus protocol: hold valid_i high for 6 cycles reading STATUS → exactly 3 accepted requests and 3 single-cycle resp_o pulses. A read of 0xC returns 0 (no macro), and a write to 0xC is ignored.
- IRQ (ORION_UART_IRQ_EN): set IRQEN=1 while idle → irq_o=1. Write a byte → irq_o=0 the next cycle, and irq_o returns to 1 after the stop bit plus 1 cycle.
